// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path arbiter.
package uart_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_XFER
  } arb_state_t;

  // Bits needed to index v entries, never less than one.
  function automatic int unsigned clog2_min1(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first asserted request strictly after ptr, wrapping.
module rr_pick
  import uart_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [PW-1:0] idx,
  output logic          any
);

  // Scan ptr+1 .. ptr+N modulo N and keep the first hit
  always_comb begin
    int unsigned j;
    j      = 0;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      j = (32'(ptr) + k) % N;
      if (!any && req[j[PW-1:0]]) begin
        any                 = 1'b1;
        onehot[j[PW-1:0]]   = 1'b1;
        idx                 = j[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter in front of the UART tx FIFO write port.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  input  logic                      fifo_full,
  output logic                      fifo_wr,
  output logic [DATA_W-1:0]         fifo_wr_data,
  output logic [N_REQ-1:0]          grant,
  output logic                      busy,
  output logic                      preempt
);

  localparam int unsigned PW = clog2_min1(N_REQ);

  arb_state_t       state;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    owner;
  logic [7:0]       burst_cnt;
  logic [7:0]       idle_cnt;
  logic [N_REQ-1:0] pick_oh;
  logic [PW-1:0]    pick_idx;
  logic             pick_any;
  logic             owner_valid;
  logic             owner_last;
  logic             beat;

  rr_pick #(
    .N  (N_REQ),
    .PW (PW)
  ) u_pick (
    .req    (req_valid),
    .ptr    (ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Owner handshake and zero-latency pass-through of the owner's byte to the FIFO
  always_comb begin
    req_ready    = (state == ST_XFER && !fifo_full) ? grant : '0;
    owner_valid  = req_valid[owner];
    owner_last   = req_last[owner];
    beat         = (state == ST_XFER) && owner_valid && !fifo_full;
    fifo_wr      = beat;
    fifo_wr_data = beat ? req_data[owner*DATA_W +: DATA_W] : '0;
  end

  // Arbitration FSM with burst/idle accounting; a last beat ends the grant without preempt
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      grant     <= '0;
      ptr       <= PW'(N_REQ - 1);
      owner     <= '0;
      burst_cnt <= '0;
      idle_cnt  <= '0;
      busy      <= 1'b0;
      preempt   <= 1'b0;
    end else begin
      preempt <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            state     <= ST_XFER;
            grant     <= pick_oh;
            ptr       <= pick_idx;
            owner     <= pick_idx;
            busy      <= 1'b1;
            burst_cnt <= '0;
            idle_cnt  <= '0;
          end
        end
        ST_XFER: begin
          if (beat) begin
            if (owner_last || burst_cnt == 8'(MAX_BURST - 1)) begin
              state     <= ST_IDLE;
              grant     <= '0;
              busy      <= 1'b0;
              burst_cnt <= '0;
              idle_cnt  <= '0;
              preempt   <= !owner_last;
            end else begin
              burst_cnt <= burst_cnt + 8'd1;
              idle_cnt  <= '0;
            end
          end else if (!owner_valid && !fifo_full) begin
            if (idle_cnt == 8'(TIMEOUT - 1)) begin
              state     <= ST_IDLE;
              grant     <= '0;
              busy      <= 1'b0;
              burst_cnt <= '0;
              idle_cnt  <= '0;
              preempt   <= 1'b1;
            end else begin
              idle_cnt <= idle_cnt + 8'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-requester byte queues, round-robin model.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int MAXB = 16;
  localparam int TMO  = 255;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   req_valid, req_last, req_ready, grant;
  logic [N*W-1:0] req_data;
  logic           fifo_full, fifo_wr, busy, preempt;
  logic [W-1:0]   fifo_wr_data;

  uart_tx_arbiter #(
    .N_REQ     (N),
    .DATA_W    (W),
    .MAX_BURST (MAXB),
    .TIMEOUT   (TMO)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr      (fifo_wr),
    .fifo_wr_data (fifo_wr_data),
    .grant        (grant),
    .busy         (busy),
    .preempt      (preempt)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [W:0] tx_q[N][$];   // {last, data} still to be offered by requester i
  logic [W-1:0] exp_q[N][$]; // bytes expected on the FIFO port from requester i
  int         gap[N];
  int         gap_max = 0;
  bit         rand_full = 1'b0;
  bit         full_force = 1'b0;
  int         wr_count = 0;
  int         gseq[$];
  int         m_ptr = N - 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_winner(input logic [N-1:0] v, input int p);
    for (int k = 1; k <= N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic bit tx_pending();
    for (int i = 0; i < N; i++) if (tx_q[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic push_byte(input int r, input logic [W-1:0] d, input bit last);
    tx_q[r].push_back({last, d});
    exp_q[r].push_back(d);
  endtask

  task automatic push_pkt(input int r, input int len, input logic [W-1:0] base, input bit with_last);
    for (int k = 0; k < len; k++) push_byte(r, base + W'(k), with_last && (k == len - 1));
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((tx_pending() || grant != '0) && n < budget) begin
      step();
      n++;
    end
    check({name, "_drain"}, n < budget, 1);
  endtask

  task automatic wait_grant(input string name, input logic [N-1:0] mask, input int budget);
    int n;
    n = 0;
    while (grant !== mask && n < budget) begin
      step();
      n++;
    end
    check({name, "_grant_wait"}, grant, mask);
  endtask

  // Requester driver: AXI-style, valid held with stable data until accepted
  initial begin
    logic [N-1:0] acc;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < N; i++) gap[i] = 0;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          void'(tx_q[i].pop_front());
          gap[i] = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        end else if (!req_valid[i] && gap[i] > 0) begin
          gap[i]--;
        end
        if (tx_q[i].size() > 0 && gap[i] == 0) begin
          logic [W:0] e;
          e = tx_q[i][0];
          req_valid[i]         = 1'b1;
          req_data[i*W +: W]   = e[W-1:0];
          req_last[i]          = e[W];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
      fifo_full = rand_full ? ($urandom_range(3, 0) == 0) : full_force;
    end
  end

  // Monitor: arbitration order, grant locking, release reasons and byte scoreboard
  initial begin
    logic [N-1:0] prev_grant, prev_valid;
    int  beats, idle_run, o, w;
    bit  last_seen, exp_beat, rel;
    prev_grant = '0;
    prev_valid = '0;
    beats = 0; idle_run = 0; last_seen = 1'b0; o = 0; w = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        m_ptr = N - 1;
        prev_grant = '0;
        prev_valid = '0;
        beats = 0; idle_run = 0; last_seen = 1'b0;
        continue;
      end
      check("grant_onehot0", $countones(grant) <= 1, 1);
      check("busy", busy, grant != '0);
      rel = last_seen || beats == MAXB || idle_run == TMO;
      if (prev_grant == '0 && grant != '0) begin
        w = rr_winner(prev_valid, m_ptr);
        check("rr_winner", grant, (w < 0) ? 0 : (1 << w));
        if (w >= 0) m_ptr = w;
        gseq.push_back(w);
        beats = 0; idle_run = 0; last_seen = 1'b0;
        check("preempt_quiet", preempt, 0);
      end else if (prev_grant == '0) begin
        check("missed_arbitration", prev_valid != '0, 0);
        check("preempt_quiet", preempt, 0);
      end else if (grant == '0) begin
        check("release_reason", rel, 1);
        check("preempt_pulse", preempt, !last_seen);
      end else begin
        check("grant_locked", grant, prev_grant);
        check("release_missing", rel, 0);
        check("preempt_quiet", preempt, 0);
      end
      if (grant != '0) begin
        o = 0;
        for (int i = N - 1; i >= 0; i--) if (grant[i]) o = i;
        exp_beat = req_valid[o] && !fifo_full;
        check("req_ready", req_ready, fifo_full ? '0 : grant);
        check("fifo_wr", fifo_wr, exp_beat);
        if (exp_beat) begin
          wr_count++;
          if (exp_q[o].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got 0x%0h from req %0d expected nothing", fifo_wr_data, o);
          end else begin
            check("wr_data", fifo_wr_data, exp_q[o].pop_front());
          end
          beats++;
          last_seen = req_last[o];
          idle_run = 0;
        end else begin
          check("wr_data_zero", fifo_wr_data, 0);
          if (!req_valid[o] && !fifo_full) idle_run++;
        end
      end else begin
        check("ready_idle", req_ready, 0);
        check("wr_idle", fifo_wr, 0);
      end
      prev_grant = grant;
      prev_valid = req_valid;
    end
  end

  // Directed scenarios followed by a randomized phase
  initial begin
    int t0, n, r, len;
    repeat (2) @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_preempt", preempt, 0);
    check("rst_fifo_wr", fifo_wr, 0);
    check("rst_ready", req_ready, 0);
    @(posedge clk);
    #3 reset_n = 1'b1;
    step();

    // 1: single 3-byte packet from req0
    t0 = wr_count;
    push_byte(0, 8'h41, 1'b0);
    push_byte(0, 8'h42, 1'b0);
    push_byte(0, 8'h43, 1'b1);
    step();
    check("t1_valid_seen", req_valid[0], 1);
    check("t1_no_grant_yet", grant, 0);
    step();
    check("t1_grant", grant, 4'b0001);
    check("t1_first_wr", fifo_wr, 1);
    check("t1_first_data", fifo_wr_data, 8'h41);
    wait_drain("t1", 20);
    check("t1_wr_count", wr_count - t0, 3);

    // 2: req1/req2 alternate on continuous 2-byte packets
    gseq.delete();
    push_pkt(1, 2, 8'h10, 1'b1);
    push_pkt(1, 2, 8'h14, 1'b1);
    push_pkt(2, 2, 8'h20, 1'b1);
    push_pkt(2, 2, 8'h24, 1'b1);
    wait_drain("t2", 40);
    check("t2_grants", gseq.size(), 4);
    if (gseq.size() == 4) begin
      check("t2_g0", gseq[0], 1);
      check("t2_g1", gseq[1], 2);
      check("t2_g2", gseq[2], 1);
      check("t2_g3", gseq[3], 2);
    end

    // 3: burst quota forces rotation after 16 beats
    t0 = wr_count;
    push_pkt(3, 20, 8'h60, 1'b0);
    n = 0;
    while (!preempt && n < 100) begin
      step();
      n++;
    end
    check("t3_preempt_seen", preempt, 1);
    check("t3_burst_writes", wr_count - t0, 16);
    check("t3_released", grant, 0);
    step();
    check("t3_regrant", grant, 4'b1000);
    wait_drain("t3", 400);
    check("t3_total", wr_count - t0, 20);

    // 4: long back-pressure never times out
    full_force = 1'b1;
    t0 = wr_count;
    push_pkt(0, 2, 8'h70, 1'b1);
    wait_grant("t4", 4'b0001, 10);
    repeat (300) step();
    check("t4_grant_held", grant, 4'b0001);
    check("t4_no_write", wr_count - t0, 0);
    full_force = 1'b0;
    step();
    check("t4_write_after_full", fifo_wr, 1);
    check("t4_data_after_full", fifo_wr_data, 8'h70);
    wait_drain("t4", 20);

    // 5: silent owner released after exactly TIMEOUT idle cycles
    push_byte(2, 8'h99, 1'b0);
    wait_grant("t5", 4'b0100, 10);
    check("t5_beat", fifo_wr, 1);
    push_pkt(0, 2, 8'h80, 1'b1);
    n = 0;
    while (grant != '0 && n < 400) begin
      step();
      n++;
    end
    check("t5_idle_cycles", n, TMO + 1);
    check("t5_preempt", preempt, 1);
    step();
    check("t5_next_owner", grant, 4'b0001);
    wait_drain("t5", 20);

    // 6: asynchronous reset mid-packet
    t0 = wr_count;
    push_pkt(1, 6, 8'hA0, 1'b1);
    push_pkt(0, 2, 8'hB0, 1'b1);
    n = 0;
    while (wr_count - t0 < 2 && n < 20) begin
      step();
      n++;
    end
    check("t6_owner", grant, 4'b0010);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("t6_rst_grant", grant, 0);
    check("t6_rst_wr", fifo_wr, 0);
    check("t6_rst_busy", busy, 0);
    @(posedge clk);
    #3 reset_n = 1'b1;
    step();
    check("t6_idle_after_rst", grant, 0);
    step();
    check("t6_req0_first", grant, 4'b0001);
    wait_drain("t6", 60);

    // Randomized traffic with gaps and random back-pressure
    rand_full = 1'b1;
    gap_max = 3;
    for (int p = 0; p < 40; p++) begin
      r   = int'($urandom_range(N - 1, 0));
      len = int'($urandom_range(20, 1));
      push_pkt(r, len, W'($urandom), 1'b1);
    end
    wait_drain("rand", 20000);
    rand_full = 1'b0;
    step();
    for (int i = 0; i < N; i++) check("scoreboard_left", exp_q[i].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

endmodule
